flash_loader: RTL and testbench
===============================

Name: flash_loader

Overview:
- SPI-flash-to-SRAM image loader for the memory initializer path; sits directly upstream of the memory controller's init write port.
- After reset, on `start` it reads LENGTH bytes from the configuration flash at ROM_OFFSET using command 0x03.
- It streams each byte into SRAM as an address/data/write-strobe triple and holds `busy` high so the CPU stays stalled.
- It talks to the flash pins itself: SPI mode 0, MSB first.

Parameters:
- ROM_OFFSET, 24'h013256, flash byte address of the first image byte.
- LENGTH, 131072, number of bytes to copy; legal range 1..131072.
- SCK_DIV, 2, clk28 cycles per SCK half-period; minimum 1.
- WR_HOLD, 2, clk28 cycles `ram_wren` stays high per byte; minimum 1.

Ports:
- clk28, input, 1, system clock (28 MHz).
- rst, input, 1, synchronous active-high reset.
- start, input, 1, level-sampled request to begin a copy.
- flash_cs_n, output, 1, flash chip select, active low.
- flash_sck, output, 1, SPI clock; idles low.
- flash_mosi, output, 1, serial command/address to flash.
- flash_miso, input, 1, serial data from flash.
- ram_addr, output, 17, SRAM byte index (0..LENGTH-1).
- ram_data, output, 8, byte to write.
- ram_wren, output, 1, SRAM write strobe.
- busy, output, 1, copy in progress.
- done, output, 1, sticky; set when a copy has completed.

Behaviour:
- Interface:
  - One clock, clk28; all state changes on its rising edge.
  - `rst` is synchronous and active-high; it overrides every other input, including `start`, in the same cycle.
- Reset values: flash_cs_n=1, flash_sck=0, flash_mosi=0, ram_addr=0, ram_data=0, ram_wren=0, busy=0, done=0; FSM in IDLE.
- FSM states: IDLE, SETUP, SHIFT_CA, SHIFT_DATA, WRITE, GAP, FINISH.
- IDLE/FINISH + start=1:
  - Next cycle: busy=1, done=0, flash_cs_n=0, ram_addr=0.
  - Shift register loaded with {8'h03, ROM_OFFSET}; bit counter=32.
  - Go to SETUP.
  - `start` in any other state is ignored.
- SETUP: hold SCK low for SCK_DIV cycles (CS setup), with flash_mosi = shift register MSB; then go to SHIFT_CA.
- SCK timing (SHIFT_CA and SHIFT_DATA):
  - Each bit is SCK low for SCK_DIV cycles, then high for SCK_DIV cycles.
  - flash_miso is sampled on the clk28 edge that drives SCK 0->1.
  - flash_mosi advances to the next bit on the edge that drives SCK 1->0.
- SHIFT_CA: exactly 32 SCK pulses; after the 32nd high phase SCK returns low, MOSI=0, go to SHIFT_DATA. MISO is ignored in this state.
- SHIFT_DATA:
  - 8 SCK pulses, MISO shifted in MSB first.
  - After the 8th high phase SCK returns low and stays low.
  - Go to WRITE with ram_data = assembled byte.
- WRITE:
  - ram_wren=1 for exactly WR_HOLD cycles.
  - ram_addr and ram_data are stable for the whole pulse and for 1 cycle after it.
- GAP (1 cycle, ram_wren=0):
  - If ram_addr == LENGTH-1: go to FINISH.
  - Otherwise: ram_addr increments, go to SHIFT_DATA.
  - SCK is paused (low) during WRITE/GAP; flash_cs_n stays low so the read stream continues.
- FINISH:
  - flash_cs_n=1, busy=0, done=1; ram_addr keeps its last value.
  - done stays 1 until the next accepted start or rst.
- Cycle budget:
  - Setup = SCK_DIV + 64*SCK_DIV cycles.
  - Per byte = 16*SCK_DIV + WR_HOLD + 1 cycles.
  - Requirement: busy falls exactly 1 + 65*SCK_DIV + LENGTH*(16*SCK_DIV + WR_HOLD + 1) cycles after the start-sampling edge.
- ram_addr never wraps; LENGTH=131072 ends at 17'h1FFFF.
- rst mid-operation:
  - All outputs take their reset values on the next edge; flash_cs_n goes high, aborting the flash read.
  - A ram_wren pulse in progress is cut short.
  - No further writes occur; done=0.
- flash_miso is treated as already synchronous; there is no internal synchronizer.

Test Plan:
1. Reset values: hold rst for 3 cycles with start=1 -> all outputs at reset values, busy stays 0, no SCK edges.
2. Command/address (LENGTH=4, SCK_DIV=2): pulse start.
   - flash_cs_n falls next cycle.
   - Bits captured on SCK rising edges = 0x03, 0x01, 0x32, 0x56.
   - Exactly 32 pulses before the data phase; each SCK half-period is 2 cycles.
3. Data copy: flash model returns 0xA5, 0x3C, 0xFF, 0x00.
   - Writes land at (0,A5), (1,3C), (2,FF), (3,00).
   - Each ram_wren pulse is 2 cycles wide, followed by a 1-cycle gap.
   - 64 total SCK pulses; flash_cs_n rises with done=1.
   - busy falls exactly 1 + 130 + 4*35 = 271 cycles after start.
4. Start handling:
   - start held high through a copy -> only one copy.
   - start after done -> new copy from ram_addr=0; done clears on acceptance.
5. Reset mid-copy: assert rst during byte 2's SHIFT_DATA -> next cycle flash_cs_n=1, busy=0, ram_wren=0, and no write to address 2 ever appears.
6. Edge parameters: SCK_DIV=1, WR_HOLD=1, LENGTH=1 -> single write at address 0, busy duration 1 + 65 + 18 = 84 cycles, SCK period 2 cycles.

Source files
------------

// File: rtl/flash_loader.sv
// flash_loader: copies LENGTH bytes from the configuration SPI flash (READ 0x03,
// mode 0, MSB first) into SRAM through the init write port, holding busy meanwhile.
module flash_loader #(
  parameter logic [23:0] ROM_OFFSET = 24'h013256,
  parameter int unsigned LENGTH     = 131072,
  parameter int unsigned SCK_DIV    = 2,
  parameter int unsigned WR_HOLD    = 2
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        start,
  output logic        flash_cs_n,
  output logic        flash_sck,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic [16:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] SETUP      = 3'd1;
  localparam logic [2:0] SHIFT_CA   = 3'd2;
  localparam logic [2:0] SHIFT_DATA = 3'd3;
  localparam logic [2:0] WRITE      = 3'd4;
  localparam logic [2:0] GAP        = 3'd5;
  localparam logic [2:0] FINISH     = 3'd6;

  localparam int unsigned DIV_W = $clog2(SCK_DIV + 1);
  localparam int unsigned WR_W  = $clog2(WR_HOLD + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCK_DIV - 1);
  localparam logic [DIV_W-1:0] SETUP_LAST = DIV_W'(SCK_DIV);
  localparam logic [WR_W-1:0]  WR_LAST    = WR_W'(WR_HOLD - 1);
  localparam logic [16:0]      ADDR_LAST  = 17'(LENGTH - 1);
  localparam logic [31:0]      CMD_ADDR   = {8'h03, ROM_OFFSET};

  logic [2:0]       state;
  logic [31:0]      sr;
  logic [5:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [WR_W-1:0]  wr_cnt;
  logic             half_end;

  assign half_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk28) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      wr_cnt     <= '0;
      flash_cs_n <= 1'b1;
      flash_sck  <= 1'b0;
      flash_mosi <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            state      <= SETUP;
            busy       <= 1'b1;
            done       <= 1'b0;
            flash_cs_n <= 1'b0;
            ram_addr   <= '0;
            // MSB goes straight onto MOSI; sr holds the bits still to send
            sr         <= {CMD_ADDR[30:0], 1'b0};
            flash_mosi <= CMD_ADDR[31];
            bit_cnt    <= 6'd32;
            div_cnt    <= '0;
          end
        end

        // One load cycle followed by SCK_DIV cycles of CS setup.
        SETUP: begin
          if (div_cnt == SETUP_LAST) begin
            div_cnt <= '0;
            state   <= SHIFT_CA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT_CA, SHIFT_DATA: begin
          if (!half_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!flash_sck) begin
              flash_sck <= 1'b1;
              if (state == SHIFT_DATA) sr <= {sr[30:0], flash_miso};
            end else begin
              flash_sck <= 1'b0;
              bit_cnt   <= bit_cnt - 1'b1;
              if (state == SHIFT_CA) begin
                sr         <= {sr[30:0], 1'b0};
                flash_mosi <= (bit_cnt == 6'd1) ? 1'b0 : sr[31];
                if (bit_cnt == 6'd1) begin
                  state   <= SHIFT_DATA;
                  bit_cnt <= 6'd8;
                end
              end else if (bit_cnt == 6'd1) begin
                state    <= WRITE;
                ram_data <= sr[7:0];
                ram_wren <= 1'b1;
                wr_cnt   <= '0;
              end
            end
          end
        end

        WRITE: begin
          if (wr_cnt == WR_LAST) begin
            ram_wren <= 1'b0;
            state    <= GAP;
          end else begin
            wr_cnt <= wr_cnt + 1'b1;
          end
        end

        GAP: begin
          if (ram_addr == ADDR_LAST) begin
            state      <= FINISH;
            flash_cs_n <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            ram_addr <= ram_addr + 17'd1;
            bit_cnt  <= 6'd8;
            state    <= SHIFT_DATA;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboard bench for flash_loader: two instances (LENGTH=4/DIV=2/HOLD=2 and
// LENGTH=1/DIV=1/HOLD=1), each with its own behavioural mode-0 flash.
module tb_flash_loader;

  logic        clk28 = 1'b0;
  logic [1:0]  rst   = 2'b11;
  logic [1:0]  start = 2'b11;
  logic [1:0]  miso  = 2'b00;
  logic [1:0]  cs_n, sck, mosi, wren, busy, done;
  logic [16:0] addr [2];
  logic [7:0]  data [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [24:0] wq0 [$];
  logic [24:0] wq1 [$];
  int          bq0 [$];
  int          bq1 [$];
  bit   [1:0]  abort = 2'b00;

  int          pcnt [2] = '{0, 0};
  int          run  [2] = '{1, 1};
  int          wlen [2] = '{0, 0};
  int          nwr  [2] = '{0, 0};
  int          t0   [2] = '{0, 0};
  logic [31:0] cmd  [2] = '{32'h0, 32'h0};
  logic [24:0] wcur [2] = '{25'h0, 25'h0};
  logic [1:0]  p_sck  = 2'b00;
  logic [1:0]  p_wren = 2'b00;
  logic [1:0]  p_busy = 2'b00;
  logic [1:0]  p_cs   = 2'b11;

  always #5 clk28 = ~clk28;

  flash_loader #(.ROM_OFFSET(24'h013256), .LENGTH(4), .SCK_DIV(2), .WR_HOLD(2)) u_a (
    .clk28(clk28), .rst(rst[0]), .start(start[0]),
    .flash_cs_n(cs_n[0]), .flash_sck(sck[0]), .flash_mosi(mosi[0]), .flash_miso(miso[0]),
    .ram_addr(addr[0]), .ram_data(data[0]), .ram_wren(wren[0]), .busy(busy[0]), .done(done[0])
  );

  flash_loader #(.ROM_OFFSET(24'h013256), .LENGTH(1), .SCK_DIV(1), .WR_HOLD(1)) u_b (
    .clk28(clk28), .rst(rst[1]), .start(start[1]),
    .flash_cs_n(cs_n[1]), .flash_sck(sck[1]), .flash_mosi(mosi[1]), .flash_miso(miso[1]),
    .ram_addr(addr[1]), .ram_data(data[1]), .ram_wren(wren[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int div_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic int hold_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic int len_of(input int g);
    return (g == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] img(input int g, input int i);
    if (g == 1) return (i == 0) ? 8'h96 : 8'h00;
    case (i)
      0:       return 8'hA5;
      1:       return 8'h3C;
      2:       return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic bit_of(input int g, input int k);
    logic [7:0] b;
    b = img(g, k / 8);
    return b[7 - (k % 8)];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push_w(input int g, input int i, input logic [7:0] d);
    if (g == 0) wq0.push_back({17'(i), d});
    else        wq1.push_back({17'(i), d});
  endtask

  task automatic pop_w(input int g, output bit ok, output logic [24:0] v);
    ok = 1'b1;
    v  = '0;
    if (g == 0) begin
      if (wq0.size() == 0) ok = 1'b0; else v = wq0.pop_front();
    end else begin
      if (wq1.size() == 0) ok = 1'b0; else v = wq1.pop_front();
    end
  endtask

  task automatic pop_b(input int g, output bit ok, output int v);
    ok = 1'b1;
    v  = 0;
    if (g == 0) begin
      if (bq0.size() == 0) ok = 1'b0; else v = bq0.pop_front();
    end else begin
      if (bq1.size() == 0) ok = 1'b0; else v = bq1.pop_front();
    end
  endtask

  task automatic wait_done(input int g, input int limit);
    int n;
    n = 0;
    while (!(done[g] && !busy[g]) && n < limit) begin
      @(negedge clk28);
      n++;
    end
    check("done_within_budget", int'(n < limit), 1);
  endtask

  // Flash models and output monitor, sampled on the falling clock edge.
  always @(negedge clk28) begin
    bit          ok;
    logic [24:0] ew;
    int          eb;
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (!p_cs[g] && cs_n[g] && !abort[g])
        check("sck_pulse_total", pcnt[g], 32 + 8 * len_of(g));
      if (cs_n[g]) begin
        pcnt[g] = 0;
        run[g]  = 1;
        miso[g] = 1'b0;
      end else if (sck[g] != p_sck[g]) begin
        if (sck[g]) begin
          if (pcnt[g] >= 1 && pcnt[g] <= 31) check("sck_low_half", run[g], div_of(g));
          if (pcnt[g] < 32) cmd[g] = {cmd[g][30:0], mosi[g]};
          pcnt[g]++;
          if (pcnt[g] == 32) check("cmd_addr_bits", int'(cmd[g]), 32'h03013256);
        end else begin
          check("sck_high_half", run[g], div_of(g));
          if (pcnt[g] >= 32) miso[g] = bit_of(g, pcnt[g] - 32);
        end
        run[g] = 1;
      end else begin
        run[g]++;
      end

      if (wren[g] && !p_wren[g]) begin
        nwr[g]++;
        wlen[g] = 1;
        wcur[g] = {addr[g], data[g]};
        pop_w(g, ok, ew);
        check("write_expected", int'(ok), 1);
        if (ok) check("write_addr_data", int'(wcur[g]), int'(ew));
      end else if (wren[g]) begin
        wlen[g]++;
        check("write_stable", int'({addr[g], data[g]}), int'(wcur[g]));
      end else if (p_wren[g]) begin
        check("wren_width", wlen[g], hold_of(g));
        check("write_hold_after", int'({addr[g], data[g]}), int'(wcur[g]));
      end

      if (busy[g] && !p_busy[g]) begin
        t0[g] = cyc;
        check("done_clear_on_start", int'(done[g]), 0);
      end else if (!busy[g] && p_busy[g]) begin
        if (abort[g]) begin
          abort[g] = 1'b0;
        end else begin
          pop_b(g, ok, eb);
          check("busy_expected", int'(ok), 1);
          if (ok) check("busy_cycles", cyc - t0[g], eb);
          check("done_cs_at_end", int'({done[g], cs_n[g]}), 3);
        end
      end

      p_sck[g]  = sck[g];
      p_wren[g] = wren[g];
      p_busy[g] = busy[g];
      p_cs[g]   = cs_n[g];
    end
  end

  initial begin
    int n;
    repeat (3) begin
      @(negedge clk28);
      for (int g = 0; g < 2; g++)
        check("reset_state",
              int'({cs_n[g], sck[g], mosi[g], addr[g], data[g], wren[g], busy[g], done[g]}),
              int'({1'b1, 2'b00, 17'd0, 8'd0, 3'b000}));
    end
    rst   = 2'b00;
    start = 2'b00;
    repeat (2) @(negedge clk28);

    // Copy 1: single start pulse.
    for (int i = 0; i < 4; i++) push_w(0, i, img(0, i));
    bq0.push_back(271);
    start[0] = 1'b1;
    @(negedge clk28);
    start[0] = 1'b0;
    check("start_accept", int'({cs_n[0], busy[0], addr[0]}), int'({1'b0, 1'b1, 17'd0}));
    wait_done(0, 1000);

    // Copy 2: start held high through the whole copy, accepted from FINISH.
    for (int i = 0; i < 4; i++) push_w(0, i, img(0, i));
    bq0.push_back(271);
    start[0] = 1'b1;
    @(negedge clk28);
    check("restart_accept", int'({done[0], busy[0], addr[0]}), int'({1'b0, 1'b1, 17'd0}));
    wait_done(0, 1000);
    start[0] = 1'b0;
    repeat (30) @(negedge clk28);
    check("single_copy", int'({busy[0], done[0], cs_n[0]}), 3);

    // Copy 3: reset while byte 2 is being shifted in.
    push_w(0, 0, img(0, 0));
    push_w(0, 1, img(0, 1));
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(negedge clk28);
    start[0] = 1'b0;
    n = 0;
    while (pcnt[0] < 51 && n < 1000) begin
      @(negedge clk28);
      n++;
    end
    check("reach_byte2", int'(pcnt[0] >= 51), 1);
    rst[0] = 1'b1;
    @(negedge clk28);
    check("abort_outputs", int'({cs_n[0], busy[0], wren[0], done[0], sck[0]}), 16);
    rst[0] = 1'b0;
    repeat (400) @(negedge clk28);
    check("abort_write_count", nwr[0], 10);
    check("abort_queue_drained", wq0.size(), 0);

    // Minimum-parameter instance: one byte.
    push_w(1, 0, img(1, 0));
    bq1.push_back(84);
    start[1] = 1'b1;
    @(negedge clk28);
    start[1] = 1'b0;
    check("b_start_accept", int'({cs_n[1], busy[1], addr[1]}), int'({1'b0, 1'b1, 17'd0}));
    wait_done(1, 500);
    repeat (5) @(negedge clk28);
    check("b_write_count", nwr[1], 1);
    check("queues_empty", wq0.size() + wq1.size() + bq0.size() + bq1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
